// File: rtl/mdio_responder.sv
// Clause-22 MDIO PHY-side responder serving a 32x16 management register file.
// MDC is oversampled by clk; every frame action happens on a synchronized MDC rising edge.
module mdio_responder #(
  parameter logic [4:0]  PHY_ADDR     = 5'd1,
  parameter logic [15:0] PHY_ID1      = 16'h0007,
  parameter logic [15:0] PHY_ID2      = 16'hC0F1,
  parameter int unsigned PREAMBLE_MIN = 32,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mdc_i,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        link_up,
  output logic        reg_wr_stb,
  output logic [4:0]  reg_wr_addr,
  output logic [15:0] reg_wr_data,
  output logic        busy
);
  localparam int unsigned PW       = $clog2(PREAMBLE_MIN + 1);
  localparam logic [15:0] REG0_RST = 16'h3100;
  localparam logic [15:0] REG1_FIX = 16'h7809;

  typedef enum logic [2:0] {IDLE, ST, OP, PHYAD, REGAD, TA, DATA, SKIP} state_t;

  logic [SYNC_STAGES-1:0] mdc_sync;
  logic [SYNC_STAGES-1:0] mdio_sync;
  logic                   mdc_prev;
  logic                   mdc_rise;
  logic                   bit_in;

  state_t      state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic        rd_op_q, rd_op_d;
  logic        foreign_q, foreign_d;
  logic [3:0]  phy_q, phy_d;
  logic [4:0]  reg_q, reg_d;
  logic [15:0] shift_q, shift_d;
  logic        mdio_o_d, mdio_oe_d, busy_d, stb_d;
  logic [4:0]  wr_addr_d;
  logic [15:0] wr_data_d;

  logic [15:0] regs [32];
  logic        wr_en;
  logic        soft_rst;
  logic [15:0] wr_word;
  logic [4:0]  rd_addr;
  logic [15:0] rd_word;
  logic        own_rd;
  logic        own_wr;

  // Pad synchronizers; left unreset so a held-high MDC never looks like a fresh edge after reset
  always_ff @(posedge clk) begin
    mdc_sync  <= {mdc_sync[SYNC_STAGES-2:0], mdc_i};
    mdio_sync <= {mdio_sync[SYNC_STAGES-2:0], mdio_i};
    mdc_prev  <= mdc_sync[SYNC_STAGES-1];
  end

  assign mdc_rise = mdc_sync[SYNC_STAGES-1] & ~mdc_prev;
  assign bit_in   = mdio_sync[SYNC_STAGES-1];
  assign own_rd   = rd_op_q & ~foreign_q;
  assign own_wr   = ~rd_op_q & ~foreign_q;
  assign rd_addr  = {reg_q[3:0], bit_in};

  // Read view: reg0[15] self-clears, reg1 mixes live link status, IDs are constants
  always_comb begin
    rd_word = regs[rd_addr];
    case (rd_addr)
      5'd0:    rd_word = regs[0] & 16'h7FFF;
      5'd1:    rd_word = REG1_FIX | {13'd0, link_up, 2'b00};
      5'd2:    rd_word = PHY_ID1;
      5'd3:    rd_word = PHY_ID2;
      default: rd_word = regs[rd_addr];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || soft_rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= (i == 0) ? REG0_RST : 16'h0000;
    end else if (wr_en) begin
      regs[reg_q] <= wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 5'd0;
      pre_cnt_q   <= '0;
      rd_op_q     <= 1'b0;
      foreign_q   <= 1'b0;
      phy_q       <= 4'd0;
      reg_q       <= 5'd0;
      shift_q     <= 16'h0000;
      mdio_o      <= 1'b0;
      mdio_oe     <= 1'b0;
      busy        <= 1'b0;
      reg_wr_stb  <= 1'b0;
      reg_wr_addr <= 5'd0;
      reg_wr_data <= 16'h0000;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      pre_cnt_q   <= pre_cnt_d;
      rd_op_q     <= rd_op_d;
      foreign_q   <= foreign_d;
      phy_q       <= phy_d;
      reg_q       <= reg_d;
      shift_q     <= shift_d;
      mdio_o      <= mdio_o_d;
      mdio_oe     <= mdio_oe_d;
      busy        <= busy_d;
      reg_wr_stb  <= stb_d;
      reg_wr_addr <= wr_addr_d;
      reg_wr_data <= wr_data_d;
    end
  end

  // Frame decoder; bit_cnt_q holds the index of the bit arriving on this MDC rise
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    pre_cnt_d = pre_cnt_q;
    rd_op_d   = rd_op_q;
    foreign_d = foreign_q;
    phy_d     = phy_q;
    reg_d     = reg_q;
    shift_d   = shift_q;
    mdio_o_d  = mdio_o;
    mdio_oe_d = mdio_oe;
    busy_d    = busy;
    stb_d     = 1'b0;
    wr_addr_d = reg_wr_addr;
    wr_data_d = reg_wr_data;
    wr_en     = 1'b0;
    soft_rst  = 1'b0;
    wr_word   = {shift_q[14:0], bit_in};
    if (mdc_rise) begin
      bit_cnt_d = bit_cnt_q + 5'd1;
      case (state_q)
        IDLE: begin
          bit_cnt_d = 5'd0;
          if (bit_in) begin
            if (pre_cnt_q != PW'(PREAMBLE_MIN)) pre_cnt_d = pre_cnt_q + PW'(1);
          end else if (pre_cnt_q == PW'(PREAMBLE_MIN)) begin
            state_d   = ST;
            busy_d    = 1'b1;
            bit_cnt_d = 5'd1;
            pre_cnt_d = '0;
          end else begin
            pre_cnt_d = '0;
          end
        end
        ST: begin
          if (bit_in) begin
            state_d = OP;
          end else begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            bit_cnt_d = 5'd0;
          end
        end
        OP: begin
          if (bit_cnt_q == 5'd2) rd_op_d = bit_in;
          else state_d = (rd_op_q != bit_in) ? PHYAD : SKIP;
        end
        PHYAD: begin
          phy_d = {phy_q[2:0], bit_in};
          if (bit_cnt_q == 5'd8) begin
            foreign_d = ({phy_q, bit_in} != PHY_ADDR);
            state_d   = REGAD;
          end
        end
        REGAD: begin
          reg_d = {reg_q[3:0], bit_in};
          if (bit_cnt_q == 5'd13) begin
            state_d = TA;
            if (rd_op_q && !foreign_q) shift_d = rd_word;
          end
        end
        TA: begin
          if (bit_cnt_q == 5'd14) begin
            if (own_rd) begin
              mdio_oe_d = 1'b1;
              mdio_o_d  = 1'b0;
            end else if (own_wr && !bit_in) begin
              state_d = SKIP;
            end
          end else begin
            state_d = DATA;
            if (own_rd) begin
              mdio_o_d = shift_q[15];
              shift_d  = {shift_q[14:0], 1'b0};
            end else if (own_wr && bit_in) begin
              state_d = SKIP;
            end
          end
        end
        DATA: begin
          if (bit_cnt_q == 5'd31) begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            bit_cnt_d = 5'd0;
            mdio_oe_d = 1'b0;
            mdio_o_d  = 1'b0;
            if (own_wr) begin
              stb_d     = 1'b1;
              wr_addr_d = reg_q;
              wr_data_d = wr_word;
              if (reg_q == 5'd0 && wr_word[15]) soft_rst = 1'b1;
              else if (reg_q == 5'd0 || reg_q > 5'd3) wr_en = 1'b1;
            end
          end else if (own_rd) begin
            mdio_o_d = shift_q[15];
            shift_d  = {shift_q[14:0], 1'b0};
          end else begin
            shift_d = wr_word;
          end
        end
        SKIP: begin
          if (bit_cnt_q == 5'd31) begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            bit_cnt_d = 5'd0;
          end
        end
        default: begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          mdio_oe_d = 1'b0;
          bit_cnt_d = 5'd0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mdio_responder.sv
// Directed bench for mdio_responder: drives MDC/MDIO frames as a station manager
// and scores read data and write strobes against queued expectations.
module tb_mdio_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, mdc, m_oe, m_val, link_up;
  logic        mdio_o, mdio_oe, reg_wr_stb, busy;
  logic [4:0]  reg_wr_addr;
  logic [15:0] reg_wr_data;
  wire         mdio_wire = mdio_oe ? mdio_o : (m_oe ? m_val : 1'b1);

  mdio_responder dut (
    .clk(clk), .rst(rst), .mdc_i(mdc), .mdio_i(mdio_wire),
    .mdio_o(mdio_o), .mdio_oe(mdio_oe), .link_up(link_up),
    .reg_wr_stb(reg_wr_stb), .reg_wr_addr(reg_wr_addr),
    .reg_wr_data(reg_wr_data), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int stb_cnt = 0;
  logic oe_seen, busy_seen;
  logic [15:0] rd_q [$];
  logic [20:0] wr_q [$];
  logic [15:0] model [32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) model[i] = 16'h0000;
    model[0] = 16'h3100;
  endfunction

  function automatic logic [15:0] exp_rd(input logic [4:0] a);
    case (a)
      5'd0:    return model[0] & 16'h7FFF;
      5'd1:    return 16'h7809 | {13'd0, link_up, 2'b00};
      5'd2:    return 16'h0007;
      5'd3:    return 16'hC0F1;
      default: return model[a];
    endcase
  endfunction

  // Write-strobe monitor and bus activity tracking
  always @(negedge clk) begin
    if (mdio_oe) oe_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
    if (reg_wr_stb) begin
      logic [20:0] e;
      stb_cnt++;
      check("stb_expected", 32'(wr_q.size() != 0), 32'd1);
      if (wr_q.size() != 0) begin
        e = wr_q.pop_front();
        check("wr_addr", 32'(reg_wr_addr), 32'(e[20:16]));
        check("wr_data", 32'(reg_wr_data), 32'(e[15:0]));
      end
    end
  end

  task automatic send_bit(input logic drv, input logic val, output logic smp, output logic oeb);
    m_oe = drv;
    m_val = val;
    mdc = 1'b0;
    repeat (4) @(negedge clk);
    smp = mdio_wire;
    oeb = mdio_oe;
    mdc = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // s[k]/oe_s[k] are sampled just before the MDC rise of frame bit k
  task automatic frame(input int pre_len, input int zero_at, input logic rd, input logic [4:0] phy,
                       input logic [4:0] ra, input logic [15:0] wd, input int stop_at,
                       output logic [0:31] s, output logic [0:31] oe_s);
    logic [0:31] fb;
    logic smp, oeb;
    fb = {2'b01, (rd ? 2'b10 : 2'b01), phy, ra, 2'b10, wd};
    s = '1;
    oe_s = '0;
    oe_seen = 1'b0;
    busy_seen = 1'b0;
    for (int i = 0; i < pre_len; i++) send_bit(1'b1, logic'(i != zero_at), smp, oeb);
    for (int k = 0; k < 32; k++) begin
      if (k == stop_at) begin
        m_oe = !(rd && k >= 14);
        m_val = fb[k];
        mdc = 1'b0;
        repeat (4) @(negedge clk);
        mdc = 1'b1;
        return;
      end
      send_bit(!(rd && k >= 14), fb[k], smp, oeb);
      s[k] = smp;
      oe_s[k] = oeb;
    end
    m_oe = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] phy, input logic [4:0] ra, input int pre_len,
                         input int zero_at, input string tag);
    logic [0:31] s, oe_s;
    logic [15:0] got, exp;
    logic own;
    own = (phy == 5'd1) && (pre_len >= 32) && (zero_at < 0);
    if (own) rd_q.push_back(exp_rd(ra));
    frame(pre_len, zero_at, 1'b1, phy, ra, 16'h0000, -1, s, oe_s);
    for (int j = 0; j < 16; j++) got[15-j] = s[16+j];
    repeat (2) @(negedge clk);
    if (own) begin
      exp = rd_q.pop_front();
      check({tag, "_data"}, 32'(got), 32'(exp));
      check({tag, "_ta1_oe"}, 32'(oe_s[14]), 32'd0);
      check({tag, "_ta2_bit"}, 32'(s[15]), 32'd0);
      check({tag, "_end_oe"}, 32'(mdio_oe), 32'd0);
    end else begin
      check({tag, "_oe_seen"}, 32'(oe_seen), 32'd0);
    end
  endtask

  task automatic do_write(input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] d,
                          input int pre_len, input string tag);
    logic [0:31] s, oe_s;
    logic own;
    int n0;
    own = (phy == 5'd1) && (pre_len >= 32);
    n0 = stb_cnt;
    if (own) begin
      wr_q.push_back({ra, d});
      if (ra == 5'd0 && d[15]) model_reset();
      else if (ra == 5'd0 || ra > 5'd3) model[ra] = d;
    end
    frame(pre_len, -1, 1'b0, phy, ra, d, -1, s, oe_s);
    repeat (4) @(negedge clk);
    check({tag, "_stb_cnt"}, 32'(stb_cnt - n0), own ? 32'd1 : 32'd0);
    check({tag, "_oe_seen"}, 32'(oe_seen), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [0:31] s, oe_s;
    rst = 1'b1;
    mdc = 1'b0;
    m_oe = 1'b0;
    m_val = 1'b1;
    link_up = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
    check("rst_mdio_oe", 32'(mdio_oe), 32'd0);
    check("rst_mdio_o", 32'(mdio_o), 32'd0);
    check("rst_stb", 32'(reg_wr_stb), 32'd0);
    check("rst_wr_addr", 32'(reg_wr_addr), 32'd0);
    check("rst_wr_data", 32'(reg_wr_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    do_read(5'd1, 5'd2, 32, -1, "rd_id1");
    do_read(5'd1, 5'd3, 32, -1, "rd_id2");
    do_read(5'd1, 5'd0, 32, -1, "rd_reg0");
    do_read(5'd1, 5'd1, 32, -1, "rd_reg1_down");

    do_write(5'd1, 5'd4, 16'hA5C3, 32, "wr_reg4");
    do_read(5'd1, 5'd4, 32, -1, "rd_reg4");

    do_write(5'd2, 5'd4, 16'hFFFF, 32, "wr_foreign");
    do_read(5'd2, 5'd4, 32, -1, "rd_foreign");
    do_read(5'd1, 5'd4, 32, -1, "rd_reg4_kept");

    do_write(5'd1, 5'd5, 16'hBEEF, 31, "wr_pre31");
    check("pre31_busy", 32'(busy_seen), 32'd0);
    do_read(5'd1, 5'd2, 32, 20, "rd_pre_gap");
    check("pre_gap_busy", 32'(busy_seen), 32'd0);
    do_read(5'd1, 5'd5, 32, -1, "rd_reg5");

    do_write(5'd1, 5'd2, 16'h5555, 32, "wr_ro");
    do_read(5'd1, 5'd2, 32, -1, "rd_ro");

    do_write(5'd1, 5'd4, 16'h1234, 32, "wr_reg4b");
    do_write(5'd1, 5'd0, 16'h8000, 32, "wr_softrst");
    do_read(5'd1, 5'd4, 32, -1, "rd_reg4_sr");
    do_read(5'd1, 5'd0, 32, -1, "rd_reg0_sr");
    link_up = 1'b1;
    do_read(5'd1, 5'd1, 32, -1, "rd_reg1_up");

    do_write(5'd1, 5'd7, 16'h0F0F, 32, "wr_reg7");
    frame(32, -1, 1'b1, 5'd1, 5'd7, 16'h0000, 20, s, oe_s);
    @(negedge clk);
    check("mid_oe_before", 32'(mdio_oe), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_oe_after", 32'(mdio_oe), 32'd0);
    check("mid_busy_after", 32'(busy), 32'd0);
    model_reset();
    mdc = 1'b0;
    repeat (8) @(negedge clk);
    do_read(5'd1, 5'd2, 32, -1, "rd_post_rst");
    do_read(5'd1, 5'd7, 32, -1, "rd_reg7_post_rst");

    check("wr_q_empty", 32'(wr_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
